// File: rtl/countdown_1s.sv
// Preset 0..15 countdown timer with debounced start/pause and abort keys, stepping at TICK_HZ.
// Optional COUNTDOWN_HEX_EN: HEX0 shows the count (or "d" when done); otherwise HEX0 is blank.

module countdown_1s_db #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;  // debounced level, 1 = released
  logic [CW-1:0] cnt;

  // Level must differ from the debounced level for DB_CYCLES cycles in a row to flip it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module countdown_1s #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  input  logic [3:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0
);
  localparam int unsigned TICK_PERIOD = CLK_HZ / TICK_HZ;
  localparam int unsigned PW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  logic          rst_n;
  logic          start_p;
  logic          abort_p;
  logic          tick;
  state_t        state;
  state_t        state_nx;
  logic [3:0]    count;
  logic [3:0]    count_nx;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nx;
  logic [9:0]    led_nx;

  assign rst_n = KEY[0];

  countdown_1s_db #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(CLOCK_50), .rst_n(rst_n), .key_n(KEY[1]), .press(start_p)
  );

  countdown_1s_db #(.DB_CYCLES(DB_CYCLES)) u_db_abort (
    .clk(CLOCK_50), .rst_n(rst_n), .key_n(KEY[2]), .press(abort_p)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      presc <= '0;
      LEDR  <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      presc <= presc_nx;
      LEDR  <= led_nx;
    end
  end

  // Next state, count and prescaler; abort overrides start and tick.
  always_comb begin
    state_nx = state;
    count_nx = count;
    presc_nx = presc;
    tick     = (state == RUN) && (presc == PW'(TICK_PERIOD - 1));
    if (state == RUN) presc_nx = tick ? '0 : presc + PW'(1);
    if (abort_p) begin
      state_nx = IDLE;
      count_nx = SW;
      presc_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          count_nx = SW;
          presc_nx = '0;
          if (start_p) state_nx = (SW == 4'd0) ? DONE : RUN;
        end
        RUN: begin
          if (tick) count_nx = (count != 4'd0) ? count - 4'd1 : 4'd0;
          if (tick && count == 4'd1) state_nx = DONE;
          else if (start_p)          state_nx = PAUSE;
        end
        PAUSE: begin
          if (start_p) state_nx = RUN;
        end
        DONE: begin
          count_nx = '0;
          if (start_p) begin
            state_nx = IDLE;
            count_nx = SW;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    led_nx = {state_nx == DONE, state_nx == RUN, 4'b0000, count_nx};
  end

`ifdef COUNTDOWN_HEX_EN
  logic [6:0] hex_nx;

  // Active-low gfedcba decode of the next count, "d" once done.
  always_comb begin
    hex_nx = 7'h7F;
    if (state_nx == DONE) begin
      hex_nx = 7'h21;
    end else begin
      case (count_nx)
        4'h0: hex_nx = 7'h40;
        4'h1: hex_nx = 7'h79;
        4'h2: hex_nx = 7'h24;
        4'h3: hex_nx = 7'h30;
        4'h4: hex_nx = 7'h19;
        4'h5: hex_nx = 7'h12;
        4'h6: hex_nx = 7'h02;
        4'h7: hex_nx = 7'h78;
        4'h8: hex_nx = 7'h00;
        4'h9: hex_nx = 7'h10;
        4'hA: hex_nx = 7'h08;
        4'hB: hex_nx = 7'h03;
        4'hC: hex_nx = 7'h46;
        4'hD: hex_nx = 7'h21;
        4'hE: hex_nx = 7'h06;
        4'hF: hex_nx = 7'h0E;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) HEX0 <= 7'h40;
    else        HEX0 <= hex_nx;
  end
`else
  assign HEX0 = 7'h7F;
`endif
endmodule

// File: tb/tb_countdown_1s.sv
// Bench for countdown_1s: directed literal checks plus randomized keys/SW/reset
// against a behavioural model compared on every falling clock edge.

module tb_countdown_1s;
  localparam int unsigned CLK_HZ  = 100;
  localparam int unsigned TICK_HZ = 10;
  localparam int          DB      = 3;
  localparam int          TP      = CLK_HZ / TICK_HZ;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
`ifdef COUNTDOWN_HEX_EN
  localparam logic [6:0] HEX_RST = 7'h40;
  localparam logic [6:0] HEX_9   = 7'h10;
  localparam logic [6:0] HEX_DN  = 7'h21;
`else
  localparam logic [6:0] HEX_RST = 7'h7F;
  localparam logic [6:0] HEX_9   = 7'h7F;
  localparam logic [6:0] HEX_DN  = 7'h7F;
`endif

  logic       clk = 1'b0;
  logic [2:0] key = 3'b111;
  logic [3:0] sw  = 4'h0;
  logic [9:0] ledr;
  logic [6:0] hex0;
  int n_checks = 0;
  int n_fail   = 0;

  countdown_1s #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DB_CYCLES(DB)) dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr), .HEX0(hex0)
  );

  always #5 clk = ~clk;

  // Behavioural model: key sample history, start/stop state, elapsed run cycles.
  int m_st = M_IDLE;
  int m_cnt = 0;
  int m_elapsed = 0;
  bit m_armed [2];
  bit m_pend  [2];
  bit samp    [2][DB+2];

  task automatic model_reset();
    m_st = M_IDLE;
    m_cnt = 0;
    m_elapsed = 0;
    for (int k = 0; k < 2; k++) begin
      m_armed[k] = 1'b1;
      m_pend[k]  = 1'b0;
      for (int i = 0; i < DB + 2; i++) samp[k][i] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit start, abort, tick, all_lo, all_hi;
    int swv;
    start = m_pend[0];
    abort = m_pend[1];
    swv   = int'(sw);
    // A key event needs DB consecutive low samples, seen two cycles late.
    for (int k = 0; k < 2; k++) begin
      for (int i = DB + 1; i > 0; i--) samp[k][i] = samp[k][i-1];
      samp[k][0] = key[k+1];
      all_lo = 1'b1;
      all_hi = 1'b1;
      for (int i = 2; i < DB + 2; i++) begin
        if (samp[k][i]) all_lo = 1'b0;
        else            all_hi = 1'b0;
      end
      m_pend[k] = 1'b0;
      if (m_armed[k] && all_lo) begin
        m_pend[k]  = 1'b1;
        m_armed[k] = 1'b0;
      end else if (!m_armed[k] && all_hi) begin
        m_armed[k] = 1'b1;
      end
    end
    tick = (m_st == M_RUN) && (m_elapsed % TP == TP - 1);
    if (m_st == M_RUN) m_elapsed++;
    if (abort) begin
      m_st = M_IDLE;
      m_cnt = swv;
      m_elapsed = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          m_cnt = swv;
          if (start) begin
            m_elapsed = 0;
            m_st = (swv == 0) ? M_DONE : M_RUN;
          end
        end
        M_RUN: begin
          if (tick && m_cnt > 0) m_cnt--;
          if (tick && m_cnt == 0) m_st = M_DONE;
          else if (start)         m_st = M_PAUSE;
        end
        M_PAUSE: if (start) m_st = M_RUN;
        default: begin
          m_cnt = 0;
          if (start) begin
            m_st = M_IDLE;
            m_cnt = swv;
          end
        end
      endcase
    end
  endtask

  always @(posedge clk or negedge key[0]) begin
    if (!key[0]) model_reset();
    else         model_step();
  end

`ifdef COUNTDOWN_HEX_EN
  function automatic logic [6:0] seg(input int v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v & 15];
  endfunction
`endif

  function automatic logic [6:0] exp_hex();
`ifdef COUNTDOWN_HEX_EN
    return (m_st == M_DONE) ? 7'h21 : seg(m_cnt);
`else
    return 7'h7F;
`endif
  endfunction

  function automatic logic [9:0] exp_led();
    return {m_st == M_DONE, m_st == M_RUN, 4'b0000, 4'(m_cnt)};
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_ledr", ledr, exp_led());
    chk("model_hex0", 10'(hex0), 10'(exp_hex()));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a key low long enough to register; returns on the cycle the FSM reacts.
  task automatic press(input int k);
    key[k] = 1'b0;
    cyc(6);
    key[k] = 1'b1;
  endtask

  int runlen [3];

  initial begin
    #1 key[0] = 1'b0;
    #2;
    chk("rst_ledr", ledr, 10'h000);
    chk("rst_hex0", 10'(hex0), 10'(HEX_RST));
    cyc(2);
    key[0] = 1'b1;
    sw = 4'h6;
    cyc(1);
    chk("follow_sw", ledr, 10'h006);

    // 3 -> 2 -> 1 -> 0 at TP-cycle steps
    sw = 4'h3;
    cyc(6);
    press(1);
    chk("run3_entry", ledr, 10'h103);
    chk("model_run3", 10'(m_cnt), 10'd3);
    cyc(TP - 1);
    chk("run3_pre_tick", ledr, 10'h103);
    cyc(1);
    chk("run3_cnt2", ledr, 10'h102);
    cyc(TP);
    chk("run3_cnt1", ledr, 10'h101);
    cyc(TP);
    chk("run3_done", ledr, 10'h200);
    chk("run3_done_hex", 10'(hex0), 10'(HEX_DN));
    chk("model_done", 10'(m_st), 10'(M_DONE));
    cyc(6);
    press(1);
    chk("done_to_idle", ledr, 10'h003);

    // Pause at count 4 / prescaler 5, then resume
    sw = 4'h5;
    cyc(6);
    press(1);
    cyc(9);
    press(1);
    chk("pause_entry", ledr, 10'h004);
    cyc(40);
    chk("pause_hold", ledr, 10'h004);
    press(1);
    chk("resume", ledr, 10'h104);
    cyc(4);
    chk("resume_pre_tick", ledr, 10'h104);
    cyc(1);
    chk("resume_tick", ledr, 10'h103);
    cyc(6);
    press(2);
    chk("abort_run", ledr, 10'h005);

    // Zero preset goes straight to DONE
    sw = 4'h0;
    cyc(6);
    press(1);
    chk("zero_done", ledr, 10'h200);
    sw = 4'h9;
    cyc(3);
    chk("done_hold", ledr, 10'h200);
    cyc(3);
    press(1);
    chk("zero_idle", ledr, 10'h009);
    sw = 4'hA;
    cyc(1);
    chk("idle_follow", ledr, 10'h00A);

    // Bounce rejection, then a minimal valid press
    sw = 4'h7;
    cyc(6);
    key[1] = 1'b0;
    cyc(2);
    key[1] = 1'b1;
    cyc(8);
    chk("bounce_ignored", ledr, 10'h007);
    key[1] = 1'b0;
    cyc(3);
    key[1] = 1'b1;
    cyc(3);
    chk("short_press", ledr, 10'h107);
    cyc(TP);
    chk("single_event", ledr, 10'h106);
    press(2);
    chk("abort_cleanup", ledr, 10'h007);

    // Abort coincides with the tick that would take count 2 -> 1
    sw = 4'h3;
    cyc(6);
    press(1);
    sw = 4'hC;
    cyc(2 * TP - 6);
    press(2);
    chk("abort_vs_tick", ledr, 10'h00C);
    chk("model_abort", 10'(m_cnt), 10'd12);

    // Asynchronous reset mid-run at count 7
    sw = 4'h9;
    cyc(6);
    press(1);
    cyc(2 * TP);
    chk("pre_reset", ledr, 10'h107);
    #2 key[0] = 1'b0;
    #1;
    chk("async_rst_ledr", ledr, 10'h000);
    chk("async_rst_hex0", 10'(hex0), 10'(HEX_RST));
    cyc(3);
    key[0] = 1'b1;
    cyc(1);
    chk("post_reset", ledr, 10'h009);
    chk("post_reset_hex", 10'(hex0), 10'(HEX_9));

    // Random keys, presets and occasional resets
    for (int k = 0; k < 3; k++) runlen[k] = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      for (int k = 1; k < 3; k++) begin
        if (runlen[k] == 0) begin
          key[k] = ~key[k];
          if (!key[k]) runlen[k] = $urandom_range(1, 6);
          else if (k == 1) runlen[k] = $urandom_range(1, 40);
          else runlen[k] = $urandom_range(20, 150);
        end else begin
          runlen[k]--;
        end
      end
      if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 key[0] = 1'b0;
        #1;
        chk("rand_rst_ledr", ledr, 10'h000);
        @(negedge clk);
        key[0] = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
